imem_uart_loader: RTL
=====================

# imem_uart_loader

Boot-time program loader that receives a framed program image over a UART RX line and writes it word-by-word into the CPU's instruction memory through that memory's write port. It sits beside the pipelined CPU top and holds the pipeline in reset until the image has been written and verified. It is the writer for the instruction memory that the IF stage reads.

## Interface
- CLKS_PER_BIT, 868, board clock cycles per UART bit (100 MHz / 115200 baud)
- ADDR_WIDTH, 10, instruction-memory word-address width; depth = 2^ADDR_WIDTH words
- Clk  input  1  board clock; the single clock
- Rst  input  1  asynchronous, active-low reset
- RxD  input  1  UART serial input, 8N1, idle high, asynchronous to Clk
- IM_WriteEnable  output  1  one-cycle instruction-memory write strobe
- IM_Address  output  ADDR_WIDTH  word address for the write
- IM_WriteData  output  32  instruction word for the write
- CPU_Hold  output  1  high = CPU held in reset; OR'd into the CPU reset by the top level
- Done  output  1  image loaded successfully; sticky
- Error  output  1  framing, length or checksum failure; sticky

## Operation
- RxD passes through a 2-flop synchronizer. A falling edge starts a byte. The start bit is re-checked at CLKS_PER_BIT/2; if it is high, the byte is discarded. Each data bit is sampled at mid-bit, LSB first. The stop bit is sampled; a low stop bit raises framing error.
- Frame format: sync byte 0xA5, count_lo, count_hi (N = 16-bit word count), then 4·N data bytes with each word little-endian, then one checksum byte.
- Main FSM states:
  - WAIT_SYNC: non-0xA5 bytes are ignored; 0xA5 goes to CNT_LO.
  - CNT_LO → CNT_HI.
  - CNT_HI: N > 2^ADDR_WIDTH goes to ERROR; N = 0 goes to CKSUM; otherwise goes to DATA.
  - DATA: assembles 4 bytes, then writes one word. After the N-th word it goes to CKSUM.
  - CKSUM: checksum match goes to DONE; mismatch goes to ERROR.
  - DONE and ERROR are terminal; they are left only by Rst.
- A framing error in any state other than WAIT_SYNC goes to ERROR. In WAIT_SYNC, a framing error drops the byte.
- Word write: IM_Address starts at 0 and increments by 1 after each write. Byte k of a word lands in IM_WriteData[8k+7:8k].
- Checksum: 8-bit XOR of count_lo, count_hi and all data bytes. The sync byte is excluded.
- CPU_Hold is 1 in every state except DONE. Done = (state == DONE). Error = (state == ERROR).

## Timing
- Reset values: IM_WriteEnable=0, IM_Address=0, IM_WriteData=0, CPU_Hold=1, Done=0, Error=0. Rst is asserted asynchronously and de-asserted synchronously by the top level.
- A byte becomes valid internally 1 cycle after the stop-bit sample point.
- IM_WriteEnable pulses for exactly 1 cycle, 1 cycle after the 4th byte of a word becomes valid. IM_Address and IM_WriteData are stable during that cycle. IM_Address increments on the cycle after the pulse.
- Done rises and CPU_Hold falls in the same cycle, 1 cycle after the checksum byte becomes valid.
- The RxD-edge-to-byte-valid window is about 9.5·CLKS_PER_BIT + 3 cycles, from synchronizer delay plus bit sampling.
- Boundary conditions:
  - N = 2^ADDR_WIDTH is accepted. The last write is at address 2^ADDR_WIDTH−1, and the address wraps to 0 unused.
  - Reset mid-frame aborts the load and returns to WAIT_SYNC with address 0. Memory already written is left as is.
  - Bytes arriving in DONE or ERROR are received and discarded.
  - A break condition (RxD held low) produces a framing error at most once per stuck-low period; no new byte starts until RxD returns high.

## Configuration
- LOADER_CHECKSUM_EN:
  - Defined: CKSUM state and the XOR accumulator exist, and a checksum mismatch goes to ERROR.
  - Undefined: the frame has no checksum byte. After the N-th word (or N = 0) the FSM goes directly to DONE, and no accumulator is synthesized.

## Structure
- Package imem_loader_pkg holds:
  - the loader state enumeration
  - SYNC_BYTE = 8'hA5
  - CNT_BYTES = 2
  - WORD_BYTES = 4
- Sub-module uart_rx_byte (parameter CLKS_PER_BIT) contains:
  - the synchronizer, bit counter and mid-bit sampler
  - outputs: Byte[7:0], ByteValid (1-cycle pulse), FrameErr (1-cycle pulse)
- The loader FSM, byte-in-word counter, word counter, address register and checksum are in imem_uart_loader.

## Test plan
- Bench parameter CLKS_PER_BIT = 16. Send A5 02 00 78 56 34 12 EF BE AD DE plus a correct checksum → exactly two write pulses: addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF. Done=1, CPU_Hold=0, Error=0.
- Send 00 FF before A5 01 00 and one word → the leading bytes are ignored and one write occurs at addr 0.
- Corrupt the checksum byte (XOR 0x01) → the writes still occur, then Error=1, Done=0, CPU_Hold=1.
- With ADDR_WIDTH=4, send count 17 → Error=1 right after count_hi, with no write pulse. Send count 16 → 16 writes at addresses 0..15, then Done.
- Drive a low stop bit on the 2nd data byte → Error=1, and no write for the partial word.
- Assert Rst after 2 of 3 words → all outputs return to reset values. Resending the full frame writes from addr 0 and gives Done=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the UART program loader: FSM states and frame constants.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_WAIT_SYNC,
      S_CNT_LO,
      S_CNT_HI,
      S_DATA,
      S_CKSUM,
      S_DONE,
      S_ERROR
   } loader_state_t;

   localparam logic [7:0] SYNC_BYTE  = 8'hA5;
   localparam int         CNT_BYTES  = 2;
   localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// ByteValid / FrameErr pulses. A new byte needs a genuine falling edge on RxD.
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       RxD,
   output logic [7:0] Byte,
   output logic       ByteValid,
   output logic       FrameErr
);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   localparam int             CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);

   logic [1:0]    r_sync;
   logic          r_rx_prev;
   rx_state_t     r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_valid;
   logic          r_ferr;
   logic          w_rx;

   assign w_rx      = r_sync[1];
   assign Byte      = r_shift;
   assign ByteValid = r_valid;
   assign FrameErr  = r_ferr;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_sync    <= 2'b11;
         r_rx_prev <= 1'b1;
         r_state   <= RX_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], RxD};
         r_rx_prev <= w_rx;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         case (r_state)
            // Edge (not level) start keeps a stuck-low line from re-triggering.
            RX_IDLE: begin
               if (r_rx_prev && !w_rx) begin
                  r_state <= RX_START;
                  r_cnt   <= '0;
               end
            end
            RX_START: begin
               if (r_cnt == HALF) begin
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_state   <= w_rx ? RX_IDLE : RX_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (r_cnt == FULL) begin
                  r_cnt   <= '0;
                  r_shift <= {w_rx, r_shift[7:1]};
                  if (r_bit_idx == 3'd7) r_state <= RX_STOP;
                  else                   r_bit_idx <= r_bit_idx + 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (r_cnt == FULL) begin
                  r_cnt   <= '0;
                  r_state <= RX_IDLE;
                  r_valid <= w_rx;
                  r_ferr  <= !w_rx;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: receives a framed image over UART and writes it into instruction
// memory, holding the CPU in reset until done. Macro LOADER_CHECKSUM_EN adds the checksum byte.
module imem_uart_loader
   import imem_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_WIDTH   = 10
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  RxD,
   output logic                  IM_WriteEnable,
   output logic [ADDR_WIDTH-1:0] IM_Address,
   output logic [31:0]           IM_WriteData,
   output logic                  CPU_Hold,
   output logic                  Done,
   output logic                  Error
);

   localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;
`ifdef LOADER_CHECKSUM_EN
   localparam loader_state_t S_TAIL = S_CKSUM;
`else
   localparam loader_state_t S_TAIL = S_DONE;
`endif

   logic [7:0]            w_byte;
   logic                  w_byte_valid;
   logic                  w_frame_err;
   logic [15:0]           w_count;
   logic                  w_in_frame;

   loader_state_t         r_state;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [7:0]            r_cnt_lo;
   logic [15:0]           r_words_left;
   logic [1:0]            r_byte_idx;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]            r_cksum;
`endif

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .Clk       (Clk),
      .Rst       (Rst),
      .RxD       (RxD),
      .Byte      (w_byte),
      .ByteValid (w_byte_valid),
      .FrameErr  (w_frame_err)
   );

   assign w_count    = {w_byte, r_cnt_lo};
   assign w_in_frame = (r_state == S_CNT_LO) || (r_state == S_CNT_HI) ||
                       (r_state == S_DATA)   || (r_state == S_CKSUM);

   assign IM_WriteEnable = r_we;
   assign IM_Address     = r_addr;
   assign IM_WriteData   = r_wdata;
   assign CPU_Hold       = (r_state != S_DONE);
   assign Done           = (r_state == S_DONE);
   assign Error          = (r_state == S_ERROR);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state      <= S_WAIT_SYNC;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_cnt_lo     <= '0;
         r_words_left <= '0;
         r_byte_idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_cksum      <= '0;
`endif
      end else begin
         r_we <= 1'b0;
         if (r_we) r_addr <= r_addr + 1'b1;
         if (w_frame_err && w_in_frame) begin
            r_state <= S_ERROR;
         end else if (w_byte_valid) begin
            case (r_state)
               S_WAIT_SYNC: if (w_byte == SYNC_BYTE) r_state <= S_CNT_LO;
               S_CNT_LO: begin
                  r_cnt_lo <= w_byte;
`ifdef LOADER_CHECKSUM_EN
                  r_cksum  <= w_byte;
`endif
                  r_state  <= S_CNT_HI;
               end
               S_CNT_HI: begin
`ifdef LOADER_CHECKSUM_EN
                  r_cksum      <= r_cksum ^ w_byte;
`endif
                  r_words_left <= w_count;
                  r_byte_idx   <= '0;
                  if ({1'b0, w_count} > MAX_WORDS) r_state <= S_ERROR;
                  else if (w_count == 16'd0)       r_state <= S_TAIL;
                  else                             r_state <= S_DATA;
               end
               // Bytes shift in from the top so byte k ends up in bits [8k+7:8k].
               S_DATA: begin
                  r_wdata    <= {w_byte, r_wdata[31:8]};
`ifdef LOADER_CHECKSUM_EN
                  r_cksum    <= r_cksum ^ w_byte;
`endif
                  r_byte_idx <= r_byte_idx + 1'b1;
                  if (r_byte_idx == 2'(WORD_BYTES - 1)) begin
                     r_we         <= 1'b1;
                     r_words_left <= r_words_left - 1'b1;
                     if (r_words_left == 16'd1) r_state <= S_TAIL;
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               S_CKSUM: r_state <= (w_byte == r_cksum) ? S_DONE : S_ERROR;
`endif
               default: ;
            endcase
         end
      end
   end

endmodule
